// File: rtl/comm_pkg.sv
// comm_pkg: opcodes, response codes, controller states and width helpers
// shared by the console-mux command engine and its byte serializer.
// Contents: OP_* opcodes, RSP_ACK/RSP_NAK, state_e, bytes_for/sel_width/max3.
package comm_pkg;

   localparam logic [7:0] OP_RD_EN     = 8'h01;
   localparam logic [7:0] OP_RD_MAP    = 8'h02;
   localparam logic [7:0] OP_WR_EN     = 8'h03;
   localparam logic [7:0] OP_WR_MAP    = 8'h04;
   localparam logic [7:0] OP_RD_INPUTS = 8'h05;
   localparam logic [7:0] OP_CLR_CFG   = 8'h06;

   localparam logic [7:0] RSP_ACK = 8'hA5;
   localparam logic [7:0] RSP_NAK = 8'h5A;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAYLOAD,
      S_SEND
   } state_e;

   // Number of whole bytes needed to carry 'bits' bits.
   function automatic int bytes_for(input int bits);
      return (bits + 7) / 8;
   endfunction

   // Selector width per output; a single input still gets one bit.
   function automatic int sel_width(input int n_inputs);
      return (n_inputs > 2) ? $clog2(n_inputs) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/comm_tx_ser.sv
// comm_tx_ser: sends a parallel word as nbytes bytes, least-significant first.
// Latency: tx_valid_o rises the cycle after load_i; one byte per handshake.
// Backpressure: tx_data_o/tx_valid_o held stable until tx_ready_i; done_o flags the last handshake.
// Ports: clk/rst, load_i+word_i+nbytes_i (load request), tx_ready_i, tx_valid_o, tx_data_o, done_o.
module comm_tx_ser #(
   parameter int WORD_W = 32,
   parameter int CNT_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic [CNT_W-1:0]  nbytes_i,
   input  logic              tx_ready_i,
   output logic              tx_valid_o,
   output logic [7:0]        tx_data_o,
   output logic              done_o
);

   logic [WORD_W-1:0] word_q;
   logic [CNT_W-1:0]  left_q;
   logic              vld_q;
   logic              hs;

   assign hs         = vld_q && tx_ready_i;
   assign done_o     = hs && (left_q == CNT_W'(1));
   assign tx_valid_o = vld_q;
   assign tx_data_o  = word_q[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         word_q <= '0;
         left_q <= '0;
         vld_q  <= 1'b0;
      end else if (load_i) begin
         word_q <= word_i;
         left_q <= nbytes_i;
         vld_q  <= 1'b1;
      end else if (hs) begin
         // Zeros shift in, so the word is clear once the last byte leaves.
         word_q <= word_q >> 8;
         left_q <= left_q - CNT_W'(1);
         if (left_q == CNT_W'(1)) begin
            vld_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/comm_ctrl.sv
// comm_ctrl: byte command engine for the console mux; holds selectors/enable mask, answers via a byte sink.
// Latency: read response or ACK/NAK tx_valid one cycle after the deciding rx byte / timeout edge.
// Backpressure: responses wait on tx_ready; rx bytes arriving while responding are dropped and set err_overrun.
// Ports: clk, rst, rx_valid/rx_data in, tx_valid/tx_ready/tx_data out, in_pins, selectors, enabled_out, err_overrun.
module comm_ctrl
   import comm_pkg::*;
#(
   parameter int OUTPUT_COUNT   = 16,
   parameter int INPUT_COUNT    = 4,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          rx_valid,
   input  logic [7:0]                                    rx_data,
   output logic                                          tx_valid,
   input  logic                                          tx_ready,
   output logic [7:0]                                    tx_data,
   input  logic [INPUT_COUNT-1:0]                        in_pins,
   output logic [OUTPUT_COUNT*sel_width(INPUT_COUNT)-1:0] selectors,
   output logic [OUTPUT_COUNT-1:0]                       enabled_out,
   output logic                                          err_overrun
);

   localparam int SEL_W     = sel_width(INPUT_COUNT);
   localparam int MAP_W     = OUTPUT_COUNT * SEL_W;
   localparam int MAP_BYTES = bytes_for(MAP_W);
   localparam int EN_BYTES  = bytes_for(OUTPUT_COUNT);
   localparam int IN_BYTES  = bytes_for(INPUT_COUNT);
   localparam int MAX_BYTES = max3(MAP_BYTES, EN_BYTES, IN_BYTES);
   localparam int WORD_W    = MAX_BYTES * 8;
   localparam int CNT_W     = $clog2(MAX_BYTES + 1);
   localparam int TO_W      = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   state_e              state_q;
   logic [7:0]          op_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [TO_W-1:0]     to_q;
   logic [WORD_W-1:0]   shadow_q;
   logic [MAP_W-1:0]    sel_q;
   logic [OUTPUT_COUNT-1:0] en_q;
   logic                ovr_q;

   logic [WORD_W-1:0]   shadow_d;
   logic [CNT_W-1:0]    wr_bytes;
   logic                is_write;
   logic                last_byte;
   logic                to_expired;
   logic                ld;
   logic [WORD_W-1:0]   ld_word;
   logic [CNT_W-1:0]    ld_n;
   logic                tx_done;

   assign is_write   = (rx_data == OP_WR_EN) || (rx_data == OP_WR_MAP);
   assign wr_bytes   = (op_q == OP_WR_EN) ? CNT_W'(EN_BYTES) : CNT_W'(MAP_BYTES);
   assign last_byte  = (cnt_q == wr_bytes - CNT_W'(1));
   assign to_expired = (to_q == TO_LAST);

   // Shadow with the incoming payload byte merged at its position.
   always_comb begin
      shadow_d = shadow_q;
      for (int b = 0; b < MAX_BYTES; b++) begin
         if (cnt_q == CNT_W'(b)) begin
            shadow_d[b*8 +: 8] = rx_data;
         end
      end
   end

   // Serializer load request: read snapshot, ACK or NAK.
   always_comb begin
      ld      = 1'b0;
      ld_word = '0;
      ld_n    = CNT_W'(1);
      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               case (rx_data)
                  OP_RD_EN: begin
                     ld      = 1'b1;
                     ld_word = WORD_W'(en_q);
                     ld_n    = CNT_W'(EN_BYTES);
                  end
                  OP_RD_MAP: begin
                     ld      = 1'b1;
                     ld_word = WORD_W'(sel_q);
                     ld_n    = CNT_W'(MAP_BYTES);
                  end
                  OP_RD_INPUTS: begin
                     ld      = 1'b1;
                     ld_word = WORD_W'(in_pins);
                     ld_n    = CNT_W'(IN_BYTES);
                  end
                  OP_WR_EN, OP_WR_MAP: begin
                     ld = 1'b0;
                  end
                  OP_CLR_CFG: begin
                     ld      = 1'b1;
                     ld_word = WORD_W'(RSP_ACK);
                  end
                  default: begin
                     ld      = 1'b1;
                     ld_word = WORD_W'(RSP_NAK);
                  end
               endcase
            end
         end
         S_PAYLOAD: begin
            if (rx_valid && last_byte) begin
               ld      = 1'b1;
               ld_word = WORD_W'(RSP_ACK);
            end else if (!rx_valid && to_expired) begin
               ld      = 1'b1;
               ld_word = WORD_W'(RSP_NAK);
            end
         end
         default: begin
            ld = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         to_q     <= '0;
         shadow_q <= '0;
         sel_q    <= '0;
         en_q     <= '0;
         ovr_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rx_valid) begin
                  op_q <= rx_data;
                  if (is_write) begin
                     state_q  <= S_PAYLOAD;
                     cnt_q    <= '0;
                     to_q     <= '0;
                     shadow_q <= '0;
                  end else begin
                     state_q <= S_SEND;
                     if (rx_data == OP_CLR_CFG) begin
                        sel_q <= '0;
                        en_q  <= '0;
                     end
                  end
               end
            end
            S_PAYLOAD: begin
               if (rx_valid) begin
                  to_q <= '0;
                  if (last_byte) begin
                     // Whole word lands in one edge; pad bits drop off by truncation.
                     if (op_q == OP_WR_EN) begin
                        en_q <= shadow_d[OUTPUT_COUNT-1:0];
                     end else begin
                        sel_q <= shadow_d[MAP_W-1:0];
                     end
                     shadow_q <= '0;
                     state_q  <= S_SEND;
                  end else begin
                     shadow_q <= shadow_d;
                     cnt_q    <= cnt_q + CNT_W'(1);
                  end
               end else if (to_expired) begin
                  shadow_q <= '0;
                  state_q  <= S_SEND;
               end else begin
                  to_q <= to_q + TO_W'(1);
               end
            end
            S_SEND: begin
               // Includes a byte arriving on the final handshake cycle.
               if (rx_valid) begin
                  ovr_q <= 1'b1;
               end
               if (tx_done) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   comm_tx_ser #(
      .WORD_W (WORD_W),
      .CNT_W  (CNT_W)
   ) u_tx_ser (
      .clk        (clk),
      .rst        (rst),
      .load_i     (ld),
      .word_i     (ld_word),
      .nbytes_i   (ld_n),
      .tx_ready_i (tx_ready),
      .tx_valid_o (tx_valid),
      .tx_data_o  (tx_data),
      .done_o     (tx_done)
   );

   assign selectors   = sel_q;
   assign enabled_out = en_q;
   assign err_overrun = ovr_q;

endmodule

// File: tb/tb_comm_ctrl.sv
// tb_comm_ctrl: scoreboard bench for comm_ctrl with directed and random command streams.
module tb_comm_ctrl;

   localparam int OC   = 16;
   localparam int IC   = 4;
   localparam int TO   = 40;
   localparam int SW   = 2;
   localparam int MAPB = 4;
   localparam int ENB  = 2;
   localparam logic [7:0] ACK = 8'hA5;
   localparam logic [7:0] NAK = 8'h5A;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           rx_valid = 1'b0;
   logic [7:0]     rx_data = 8'h00;
   logic           tx_ready = 1'b0;
   logic           tx_valid;
   logic [7:0]     tx_data;
   logic [IC-1:0]  in_pins = '0;
   logic [OC*SW-1:0] selectors;
   logic [OC-1:0]  enabled_out;
   logic           err_overrun;

   comm_ctrl #(
      .OUTPUT_COUNT   (OC),
      .INPUT_COUNT    (IC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .in_pins     (in_pins),
      .selectors   (selectors),
      .enabled_out (enabled_out),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];
   int rdy_mode = 0;   // 0 random, 1 held low, 2 held high

   // Reference model: live config as plain per-output values.
   logic [OC-1:0] m_en = '0;
   int m_sel[OC];

   function automatic logic [OC*SW-1:0] map_vec();
      logic [OC*SW-1:0] v;
      v = '0;
      for (int k = 0; k < OC; k++) v = v | ((OC*SW)'(m_sel[k] % 4) << (k*SW));
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Sink readiness pattern, changed just after each rising edge.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       tx_ready = ($urandom_range(0, 3) != 0);
         1:       tx_ready = 1'b0;
         default: tx_ready = 1'b1;
      endcase
   end

   // Monitor: pop expected byte on each handshake and check hold stability.
   logic       hold_p = 1'b0;
   logic [7:0] hold_d = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         hold_p = 1'b0;
      end else begin
         if (hold_p) begin
            check("tx_hold_valid", tx_valid, 1);
            check("tx_hold_data", tx_data, hold_d);
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL tx_unexpected: got byte 0x%0h, expected no byte", tx_data);
            end else begin
               check("tx_byte", tx_data, exp_q.pop_front());
            end
         end
         hold_p = tx_valid && !tx_ready;
         hold_d = tx_data;
      end
   end

   // Live config may only ever jump straight to the model's committed value.
   logic [OC-1:0]    prev_en;
   logic [OC*SW-1:0] prev_sel;
   always @(negedge clk) begin
      if (enabled_out !== prev_en) check("en_change", enabled_out, m_en);
      if (selectors !== prev_sel) check("sel_change", selectors, map_vec());
      prev_en  = enabled_out;
      prev_sel = selectors;
   end

   task automatic drive(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int c = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(posedge clk);
         c++;
      end
      check(name, exp_q.size(), 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
   endtask

   task automatic cmd_rd(input logic [7:0] op);
      logic [63:0] v;
      int nb;
      case (op)
         8'h01:   begin v = 64'(m_en);      nb = ENB;  end
         8'h02:   begin v = 64'(map_vec()); nb = MAPB; end
         default: begin v = 64'(in_pins);   nb = 1;    end
      endcase
      for (int i = 0; i < nb; i++) exp_q.push_back(v[i*8 +: 8]);
      drive(op);
      wait_drain("rd_drain", 300);
   endtask

   task automatic cmd_wr(input logic [7:0] op, input logic [31:0] data, input int gap);
      int nb;
      nb = (op == 8'h03) ? ENB : MAPB;
      drive(op);
      for (int i = 0; i < nb; i++) begin
         repeat (gap) @(posedge clk);
         if (i == nb - 1) begin
            if (op == 8'h03) m_en = data[OC-1:0];
            else for (int k = 0; k < OC; k++) m_sel[k] = int'(data[k*SW +: SW]);
            exp_q.push_back(ACK);
         end
         drive(data[i*8 +: 8]);
      end
      wait_drain("wr_drain", 300);
      check("wr_live_en", enabled_out, m_en);
      check("wr_live_sel", selectors, map_vec());
   endtask

   task automatic cmd_simple(input logic [7:0] op, input logic [7:0] resp);
      if (op == 8'h06) begin
         m_en = '0;
         for (int k = 0; k < OC; k++) m_sel[k] = 0;
      end
      exp_q.push_back(resp);
      drive(op);
      wait_drain("simple_drain", 300);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int c;
      for (int k = 0; k < OC; k++) m_sel[k] = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_sel", selectors, 0);
      check("rst_en", enabled_out, 0);
      check("rst_ovr", err_overrun, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Defaults read back as zero.
      cmd_rd(8'h01);
      cmd_rd(8'h02);

      // Enable write then readback.
      cmd_wr(8'h03, 32'h0000_1234, 0);
      check("en_1234", enabled_out, 16'h1234);
      cmd_rd(8'h01);

      // Map write: out0..3 = 0,1,2,3.
      cmd_wr(8'h04, 32'h0000_00E4, 0);
      check("sel_e4", selectors, 32'h0000_00E4);
      cmd_rd(8'h02);

      // Abandoned write times out with NAK, live value kept.
      rdy_mode = 2;
      drive(8'h03);
      drive(8'hFF);
      exp_q.push_back(NAK);
      c = 0;
      while (exp_q.size() != 0 && c < TO + 50) begin
         @(posedge clk);
         c++;
      end
      check("timeout_nak", exp_q.size(), 0);
      check("timeout_not_early", (c >= TO - 1), 1);
      check("timeout_not_late", (c <= TO + 3), 1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      check("timeout_en_kept", enabled_out, 16'h1234);
      rdy_mode = 0;
      cmd_rd(8'h01);

      // Bad opcode, input read, clear.
      cmd_simple(8'h7F, NAK);
      cmd_simple(8'h00, NAK);
      in_pins = 4'b1010;
      cmd_rd(8'h05);
      cmd_simple(8'h06, ACK);
      check("clr_en", enabled_out, 0);
      check("clr_sel", selectors, 0);

      // Slow payload: each gap below the timeout must not abort.
      cmd_wr(8'h04, $urandom, TO - 8);

      // Random command mix.
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 6))
            0: cmd_rd(8'h01);
            1: cmd_rd(8'h02);
            2: cmd_wr(8'h03, $urandom, $urandom_range(0, 3));
            3: cmd_wr(8'h04, $urandom, $urandom_range(0, 3));
            4: begin in_pins = IC'($urandom_range(0, 15)); cmd_rd(8'h05); end
            5: cmd_simple(8'h06, ACK);
            default: begin
               do b = 8'($urandom_range(0, 255)); while (b >= 8'h01 && b <= 8'h06);
               cmd_simple(b, NAK);
            end
         endcase
      end

      // Overrun while a map read is stalled.
      cmd_wr(8'h04, 32'hA5C3_0F96, 0);
      check("ovr_before", err_overrun, 0);
      rdy_mode = 1;
      for (int i = 0; i < MAPB; i++) exp_q.push_back(map_vec() >> (i*8));
      drive(8'h02);
      repeat (3) @(posedge clk);
      drive(8'h01);
      @(negedge clk);
      check("ovr_set", err_overrun, 1);
      check("ovr_tx_still_valid", tx_valid, 1);
      repeat (3) @(posedge clk);
      rdy_mode = 0;
      wait_drain("ovr_drain", 300);
      repeat (10) @(posedge clk);

      // Reset mid map write: nothing commits.
      cmd_wr(8'h03, 32'h0000_BEEF, 0);
      drive(8'h04);
      drive(8'h11);
      drive(8'h22);
      @(posedge clk); #1;
      rst = 1'b1;
      m_en = '0;
      for (int k = 0; k < OC; k++) m_sel[k] = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst2_tx_valid", tx_valid, 0);
      check("rst2_tx_data", tx_data, 0);
      check("rst2_sel", selectors, 0);
      check("rst2_en", enabled_out, 0);
      check("rst2_ovr", err_overrun, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      cmd_rd(8'h02);
      cmd_rd(8'h01);

      repeat (30) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/comm_ctrl.md
Name: comm_ctrl

Overview:
Byte-level command engine for the console mux. It decodes the command stream from uart_rx, keeps the live mux configuration (per-output selectors and the enable mask), and streams responses to a TX byte sink such as the fifo feeding uart_tx. It generalises the first-generation command block with:
- arbitrary OUTPUT_COUNT/INPUT_COUNT (byte counts rounded up);
- ACK/NAK status bytes and a read-inputs command;
- atomic commit and an inter-byte timeout;
- synchronous reset.

Parameters:
OUTPUT_COUNT, 16, number of muxed outputs (1..64)
INPUT_COUNT, 4, number of selectable inputs (2..256)
TIMEOUT_CYCLES, 65536, max clk cycles between payload bytes before a write aborts (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
rx_data  in  8  received byte
tx_valid  out  1  tx_data holds a byte to send
tx_ready  in  1  sink accepts byte when tx_valid && tx_ready
tx_data  out  8  byte to send
in_pins  in  INPUT_COUNT  mux inputs, readable via RD_INPUTS
selectors  out  OUTPUT_COUNT*SEL_W  live selector map, output k = bits [k*SEL_W +: SEL_W]
enabled_out  out  OUTPUT_COUNT  live enable mask
err_overrun  out  1  sticky; an rx byte was dropped while a response was being sent

Behaviour:
- Derived widths:
  - SEL_W = max(1, clog2(INPUT_COUNT)).
  - MAP_BYTES = ceil(OUTPUT_COUNT*SEL_W/8); EN_BYTES = ceil(OUTPUT_COUNT/8); IN_BYTES = ceil(INPUT_COUNT/8).
  - Byte counter is clog2(max bytes + 1) bits wide.
- Reset values: selectors=0, enabled_out=0, tx_valid=0, tx_data=0, err_overrun=0. State=IDLE, counters and shadow registers cleared. Reset mid-transfer abandons the transfer with no commit.
- Opcodes:
  - 0x01 RD_EN, 0x02 RD_MAP, 0x03 WR_EN, 0x04 WR_MAP, 0x05 RD_INPUTS, 0x06 CLR_CFG.
  - ACK=0xA5, NAK=0x5A.
- State IDLE, on rx_valid:
  - Reads: go to SEND. Latch a snapshot of the source (enabled_out, selectors, or in_pins) that same cycle.
  - Writes: go to PAYLOAD and clear the byte counter and the timeout counter.
  - CLR_CFG: zero selectors and enabled_out on the next edge, then send ACK.
  - Any other byte, including 0x00: send NAK.
- State PAYLOAD:
  - Each rx byte goes into the shadow register at byte [cnt], least-significant byte first.
  - When the last byte is written, the shadow is copied to the live register on the next edge. All bits change in one cycle; there are no partial-update glitches. Then send ACK.
  - Pad bits above the valid width in the final byte are ignored.
  - Timeout counter resets on each rx byte. When it reaches TIMEOUT_CYCLES-1: discard the shadow, leave the live config unchanged, send NAK.
- State SEND:
  - Sends response bytes LSB byte first (RD_EN: EN_BYTES; RD_MAP: MAP_BYTES; RD_INPUTS: IN_BYTES) or a single ACK/NAK byte.
  - tx_data is stable and tx_valid held high until tx_ready. Advance on handshake. Return to IDLE in the cycle after the last handshake.
  - Unused high bits of the final byte read as 0.
- rx_valid in SEND: byte dropped, err_overrun set.
- Simultaneous last-handshake and rx_valid in the same cycle counts as overrun. IDLE accepts bytes only from the following cycle.
- Latency:
  - Read command: first tx_valid 1 cycle after the opcode strobe.
  - Write: ACK tx_valid 1 cycle after the commit edge.
- Readback after a write returns the committed live values, never the shadow.

Decomposition:
- Shared package comm_pkg holds the opcode constants, ACK/NAK, the state enum, and a function computing byte counts from bit widths.
- One natural sub-module, comm_tx_ser: takes a parallel word plus byte count and handles the valid/ready byte handshake. It is reused for all response types.

Test Plan:
- After rst, send 0x01 -> tx bytes 0x00,0x00; send 0x02 -> 0x00,0x00,0x00,0x00 (defaults, MAP_BYTES=4).
- Send 0x03,0x34,0x12 -> one ACK 0xA5. Then 0x01 -> 0x34,0x12; enabled_out==0x1234 changes in exactly one cycle.
- Send 0x04,0xE4,0x00,0x00,0x00 -> ACK; selectors[7:0]==0xE4 (out0=0,out1=1,out2=2,out3=3), others 0.
- Send 0x03,0xFF then idle TIMEOUT_CYCLES -> NAK 0x5A; enabled_out unchanged; a subsequent 0x01 returns the old value.
- Send 0x7F -> NAK; in_pins=4'b1010 and 0x05 -> 0x0A; 0x06 -> ACK with both configs zero.
- Hold tx_ready=0 during a RD_MAP response and inject an rx byte -> tx_data stable, err_overrun=1, response completes intact; assert rst mid-WR_MAP -> all outputs reset values, no commit.
